kernel3_gmem_b_m_axi_wburst_split: RTL
======================================

# kernel3_gmem_B_m_axi_wburst_split

Write-path burst splitter for the `gmem_B` AXI master. It accepts whole write requests (start address plus beat count) and the matching untagged data beats from the kernel side. It emits AXI-legal AW bursts (≤ MAX_BURST beats, never crossing a BOUNDARY-byte line) and a W stream with WLAST inserted. It sits directly upstream of `kernel3_gmem_B_m_axi_throttle`, whose `in_TOP_*` ports it drives.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data beat width; BYTES = DATA_WIDTH/8
- LEN_WIDTH, 32, width of request beat count
- MAX_BURST, 16, max beats per burst (1..256, power of two)
- BOUNDARY, 4096, burst must not cross this byte boundary (power of two, ≥ MAX_BURST*BYTES)
- LFIFO_DEPTH, 8, depth of internal burst-length FIFO
- clk  in  1  clock, all logic rising edge
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; registers hold when low
- in_REQ_ADDR  in  ADDR_WIDTH  request start byte address (must be BYTES-aligned; low bits forced 0)
- in_REQ_LEN  in  LEN_WIDTH  number of beats (0 legal)
- in_REQ_VALID / out_REQ_READY  in/out  1  request handshake
- in_DATA / in_STRB  in  DATA_WIDTH / BYTES  write beat
- in_DATA_VALID / out_DATA_READY  in/out  1  data handshake
- out_AWADDR / out_AWLEN  out  ADDR_WIDTH / 8  burst address, beats-1
- out_AWVALID / in_AWREADY  out/in  1
- out_WDATA / out_WSTRB / out_WLAST  out  DATA_WIDTH / BYTES / 1
- out_WVALID / in_WREADY  out/in  1

## Operation
- AW FSM states: IDLE, SPLIT.
- IDLE: out_REQ_READY=1. On handshake, latch addr (low log2(BYTES) bits zeroed) and remaining=in_REQ_LEN. If in_REQ_LEN==0, stay IDLE and issue nothing. Otherwise go to SPLIT.
- SPLIT: beats = min(remaining, MAX_BURST, (BOUNDARY − addr mod BOUNDARY)/BYTES). out_AWADDR=addr, out_AWLEN=beats−1.
- In SPLIT, out_AWVALID=1 only while the length FIFO is not full.
- On AW handshake: push beats into the length FIFO; addr += beats*BYTES (modulo 2^ADDR_WIDTH); remaining −= beats.
- When remaining reaches 0, return to IDLE.
- W path is combinational pass-through gated by the length FIFO: out_WVALID = in_DATA_VALID & lfifo_valid; out_DATA_READY = in_WREADY & lfifo_valid.
- A beat counter counts W handshakes. out_WLAST = (beat_cnt == head_len−1). On the WLAST handshake, pop the FIFO and clear beat_cnt.
- W may lag AW by up to LFIFO_DEPTH bursts. W never precedes its AW.

## Timing
- Reset values: out_REQ_READY=1 after reset deasserts (IDLE); out_AWVALID=0, out_WVALID=0, out_DATA_READY=0, out_WLAST=0; counters and FIFO empty.
- Request handshake to first out_AWVALID: 1 cycle.
- Bursts may issue back-to-back, one per cycle, while in_AWREADY=1 and the FIFO has space.
- A burst's length is visible to the W path the cycle after its AW handshake, so the first W beat is ≥1 cycle after its AW.
- Last-burst AW handshake → out_REQ_READY=1 the next cycle.
- Zero-length request: out_REQ_READY=1 the next cycle.
- FIFO full: out_AWVALID stays low and AW fields stay stable.
- AW push and W pop in the same cycle: occupancy is unchanged.
- out_AWADDR/out_AWLEN are stable while out_AWVALID=1 and in_AWREADY=0.
- clk_en=0: all state frozen; valids reflect frozen state.
- Reset asserted mid-operation: immediate return to IDLE; FIFO and counters cleared; in-flight data is dropped.

## Configuration
- KERNEL3_GMEM_B_WSPLIT_STAT_EN defined: adds output `out_STAT_BURSTS` (32 bits). It counts AW handshakes, wraps at 2^32, and is cleared by reset.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package holds:
  - BYTES
  - burst-length type (9 bits, 1..256)
  - FSM state enum {IDLE, SPLIT}
- The length FIFO reuses `kernel3_gmem_B_m_axi_fifo` (DATA_WIDTH 9, DEPTH LFIFO_DEPTH), with the reset polarity adapted at instantiation.
- No other sub-modules.

## Test plan
- addr 0x0, len 16, all ready → one AW (0x0, AWLEN 15); 16 W beats, WLAST on beat 16 only.
- addr 0x0, len 40 → AWs (0x000,15), (0x040,15), (0x080,7); WLAST on beats 16, 32, 40.
- addr 0xFF0, len 8 → AWs (0xFF0,3), (0x1000,3); no 4 KB crossing.
- len 0 → no AW, no W; out_REQ_READY high the next cycle.
- in_WREADY=0, 12 single-burst requests (len 16) → exactly 8 AWs issue, then out_AWVALID holds low. Releasing in_WREADY drains everything in order.
- reset low during the 5th W beat of a 16-beat burst → valids 0 in the same cycle. After release, a new len-4 request produces AWLEN 3 with WLAST on beat 4.

Source files
------------

// File: rtl/kernel3_gmem_b_m_axi_wburst_split_pkg.sv
// Shared types for the gmem_B write burst splitter.
// Optional burst counter: KERNEL3_GMEM_B_WSPLIT_STAT_EN.
package kernel3_gmem_b_m_axi_wburst_split_pkg;

  localparam int BYTES  = 4;
  localparam int BLEN_W = 9;

  typedef logic [BLEN_W-1:0] blen_t;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

endpackage

// File: rtl/kernel3_gmem_B_m_axi_fifo.sv
// Show-ahead register FIFO shared by the gmem_B master blocks.
// Active-high asynchronous reset, global clock enable.
module kernel3_gmem_B_m_axi_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW:0]           cnt;
  logic                  push;
  logic                  pop;

  assign if_full_n  = (cnt != (PW+1)'(DEPTH));
  assign if_empty_n = (cnt != '0);
  assign if_dout    = mem[rptr];
  assign push       = if_write & if_full_n;
  assign pop        = if_read & if_empty_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clk_en) begin
      if (push)
        wptr <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      if (pop)
        rptr <= (rptr == PW'(DEPTH-1)) ? '0 : rptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && push)
      mem[wptr] <= if_din;
  end

endmodule

// File: rtl/kernel3_gmem_b_m_axi_wburst_split.sv
// gmem_B write burst splitter: requests -> legal AW bursts + W with WLAST.
// Define KERNEL3_GMEM_B_WSPLIT_STAT_EN to add out_STAT_BURSTS.
module kernel3_gmem_b_m_axi_wburst_split
  import kernel3_gmem_b_m_axi_wburst_split_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = BYTES * 8,
  parameter int LEN_WIDTH   = 32,
  parameter int MAX_BURST   = 16,
  parameter int BOUNDARY    = 4096,
  parameter int LFIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [ADDR_WIDTH-1:0]   in_REQ_ADDR,
  input  logic [LEN_WIDTH-1:0]    in_REQ_LEN,
  input  logic                    in_REQ_VALID,
  output logic                    out_REQ_READY,
  input  logic [DATA_WIDTH-1:0]   in_DATA,
  input  logic [DATA_WIDTH/8-1:0] in_STRB,
  input  logic                    in_DATA_VALID,
  output logic                    out_DATA_READY,
  output logic [ADDR_WIDTH-1:0]   out_AWADDR,
  output logic [7:0]              out_AWLEN,
  output logic                    out_AWVALID,
  input  logic                    in_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_WSTRB,
  output logic                    out_WLAST,
  output logic                    out_WVALID,
  input  logic                    in_WREADY
`ifdef KERNEL3_GMEM_B_WSPLIT_STAT_EN
  ,
  output logic [31:0]             out_STAT_BURSTS
`endif
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int BW = $clog2(BOUNDARY);
  localparam int AW = ADDR_WIDTH;
  localparam int LW = LEN_WIDTH;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_d;
  logic [LW-1:0]   rem_q;
  logic [LW-1:0]   rem_d;
  logic [BW:0]     room;
  logic [LW-1:0]   cand;
  blen_t           beats;
  logic            lf_full_n;
  logic            lf_valid;
  blen_t           lf_head;
  blen_t           cnt_q;
  logic            aw_hs;
  logic            w_hs;

  // Beats left before the next BOUNDARY line, in data-beat units.
  always_comb begin
    room = ((BW+1)'(BOUNDARY) - {1'b0, addr_q[BW-1:0]}) >> SH;
    cand = LW'(MAX_BURST);
    if (LW'(room) < cand)
      cand = LW'(room);
    if (rem_q < cand)
      cand = rem_q;
    beats = blen_t'(cand);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    out_REQ_READY = 1'b0;
    out_AWVALID   = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_REQ_READY = 1'b1;
        if (in_REQ_VALID) begin
          addr_d = in_REQ_ADDR & ~AW'(NB-1);
          rem_d  = in_REQ_LEN;
          if (in_REQ_LEN != '0)
            state_d = SPLIT;
        end
      end
      SPLIT: begin
        out_AWVALID = lf_full_n;
        if (lf_full_n && in_AWREADY) begin
          addr_d = addr_q + (AW'(beats) << SH);
          rem_d  = rem_q - LW'(beats);
          if (rem_q == LW'(beats))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign out_AWADDR = addr_q;
  assign out_AWLEN  = 8'(beats - 1'b1);
  assign aw_hs      = out_AWVALID & in_AWREADY;

  kernel3_gmem_B_m_axi_fifo #(
    .DATA_WIDTH (BLEN_W),
    .DEPTH      (LFIFO_DEPTH)
  ) u_lfifo (
    .clk        (clk),
    .reset      (~reset),
    .clk_en     (clk_en),
    .if_write   (aw_hs),
    .if_din     (beats),
    .if_full_n  (lf_full_n),
    .if_read    (w_hs & out_WLAST),
    .if_dout    (lf_head),
    .if_empty_n (lf_valid)
  );

  assign out_WDATA      = in_DATA;
  assign out_WSTRB      = in_STRB;
  assign out_WVALID     = in_DATA_VALID & lf_valid;
  assign out_DATA_READY = in_WREADY & lf_valid;
  assign out_WLAST      = lf_valid & (cnt_q == blen_t'(lf_head - 1'b1));
  assign w_hs           = out_WVALID & in_WREADY;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (clk_en && w_hs)
      cnt_q <= out_WLAST ? '0 : cnt_q + 1'b1;
  end

`ifdef KERNEL3_GMEM_B_WSPLIT_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_STAT_BURSTS <= '0;
    else if (clk_en && aw_hs)
      out_STAT_BURSTS <= out_STAT_BURSTS + 1'b1;
  end
`endif

endmodule
